// File: rtl/core_pipe_exec_mdu_if.sv
// ---------------------------------------------------------------------------
// core_pipe_exec_mdu_if
// Request/response bundle between an issue stage and the multiply/divide
// unit core_pipe_exec_mdu.
//
// Signals
//   valid             request strobe; held stable until ready or flush
//   flush             abort any in-flight operation
//   opr_a, opr_b      rs1 / rs2 operands (XLEN bits)
//   op_mul..op_remu   one-hot operation select
//   op_w              32-bit word operation (ignored when XLEN=32)
//   ready             single-cycle result strobe
//   result            result, meaningful only while ready=1
//   busy              an accepted operation is held by the unit
//
// Modports
//   master  issue side: drives the request, observes the response
//   slave   unit side: observes the request, drives the response
// ---------------------------------------------------------------------------
interface core_pipe_exec_mdu_if #(
  parameter int XLEN = 64
);
  logic            valid;
  logic            flush;
  logic [XLEN-1:0] opr_a;
  logic [XLEN-1:0] opr_b;
  logic            op_mul;
  logic            op_mulh;
  logic            op_mulhsu;
  logic            op_mulhu;
  logic            op_div;
  logic            op_divu;
  logic            op_rem;
  logic            op_remu;
  logic            op_w;
  logic            ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output valid, flush, opr_a, opr_b,
    output op_mul, op_mulh, op_mulhsu, op_mulhu,
    output op_div, op_divu, op_rem, op_remu, op_w,
    input  ready, result, busy
  );

  modport slave (
    input  valid, flush, opr_a, opr_b,
    input  op_mul, op_mulh, op_mulhsu, op_mulhu,
    input  op_div, op_divu, op_rem, op_remu, op_w,
    output ready, result, busy
  );
endinterface

// File: rtl/core_pipe_exec_mdu.sv
// ---------------------------------------------------------------------------
// core_pipe_exec_mdu
// Iterative RISC-V M-extension multiply/divide unit.
//   * Multiplies: shift-and-add on operand magnitudes, MUL_UNROLL multiplier
//     bits retired per cycle, W/MUL_UNROLL cycles in BUSY.
//   * Divides/remainders: restoring radix-2 division, W cycles in BUSY.
//   * Divide by zero and signed overflow are resolved at acceptance and go
//     straight to DONE.
//   * Signs are stripped at acceptance and re-applied when the result is
//     formed in DONE.
//
// Ports
//   g_clk    clock, rising edge
//   g_reset  asynchronous active-high reset
//   mdu      core_pipe_exec_mdu_if.slave request/response bundle
//
// Parameters
//   XLEN        datapath width, 32 or 64
//   MUL_UNROLL  multiplier bits per cycle, 1/2/4/8
// ---------------------------------------------------------------------------
module core_pipe_exec_mdu #(
  parameter int XLEN       = 64,
  parameter int MUL_UNROLL = 1
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  core_pipe_exec_mdu_if.slave  mdu
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int U  = MUL_UNROLL;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {K_MUL_LO, K_MUL_HI, K_QUOT, K_REM} kind_t;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] width_mask(input logic w32);
    return w32 ? XLEN'(32'hFFFF_FFFF) : {XLEN{1'b1}};
  endfunction

  // Two's-complement magnitude of a W-bit value held in an XLEN container.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            neg,
                                                input logic [XLEN-1:0] mask);
    return neg ? ((-v) & mask) : (v & mask);
  endfunction

  // Sign-extend a 32-bit word result to XLEN.
  function automatic logic [XLEN-1:0] sext_word(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  kind_t             kind_q;
  logic              neg_q;
  logic              w32_q;
  logic [XLEN-1:0]   mcand_q;   // multiplicand (mul) or divisor magnitude (div)
  logic [XLEN-1:0]   shift_q;   // multiplier digits (mul) or dividend/quotient (div)
  logic [2*XLEN-1:0] acc_q;     // product (mul) or partial remainder in low half (div)

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  logic [7:0]      ops;
  logic            accept;
  logic            w32_in;
  logic [XLEN-1:0] mask_in, a_w, b_w, a_mag, b_mag, min_w;
  logic            a_sbit, b_sbit, sa, sb;
  logic            is_mul_in, signed_div, div0, ovf;
  kind_t           kind_in;
  logic            neg_in;
  logic [CW-1:0]   cnt_init;

  assign ops = {mdu.op_mul, mdu.op_mulh, mdu.op_mulhsu, mdu.op_mulhu,
                mdu.op_div, mdu.op_divu, mdu.op_rem, mdu.op_remu};

  assign accept = (state_q == IDLE) && mdu.valid && !mdu.flush && $onehot(ops);

  always_comb begin
    w32_in     = (XLEN == 32) || mdu.op_w;
    mask_in    = width_mask(w32_in);
    a_w        = mdu.opr_a & mask_in;
    b_w        = mdu.opr_b & mask_in;
    a_sbit     = w32_in ? mdu.opr_a[31] : mdu.opr_a[XLEN-1];
    b_sbit     = w32_in ? mdu.opr_b[31] : mdu.opr_b[XLEN-1];
    signed_div = mdu.op_div | mdu.op_rem;
    sa         = (mdu.op_mulh | mdu.op_mulhsu | signed_div) & a_sbit;
    sb         = (mdu.op_mulh | signed_div) & b_sbit;
    a_mag      = magnitude(mdu.opr_a, sa, mask_in);
    b_mag      = magnitude(mdu.opr_b, sb, mask_in);
    min_w      = w32_in ? XLEN'(32'h8000_0000) : (XLEN'(1) << (XLEN - 1));
    is_mul_in  = mdu.op_mul | mdu.op_mulh | mdu.op_mulhsu | mdu.op_mulhu;
    div0       = !is_mul_in && (b_w == '0);
    ovf        = signed_div && (a_w == min_w) && (b_w == mask_in);

    kind_in = K_REM;
    neg_in  = sa;
    if (mdu.op_mul) begin
      kind_in = K_MUL_LO;
      neg_in  = 1'b0;
    end else if (is_mul_in) begin
      kind_in = K_MUL_HI;
      neg_in  = sa ^ sb;
    end else if (mdu.op_div | mdu.op_divu) begin
      kind_in = K_QUOT;
      neg_in  = sa ^ sb;
    end

    if (is_mul_in) cnt_init = w32_in ? CW'(32 / U) : CW'(XLEN / U);
    else           cnt_init = w32_in ? CW'(32) : CW'(XLEN);
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (div0 || ovf) ? DONE : BUSY;
      BUSY:    if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // flush wins over both acceptance and completion
    if (mdu.flush) state_d = IDLE;
  end

  // -------------------------------------------------------------------------
  // Iteration step
  // -------------------------------------------------------------------------
  logic              is_mul_q;
  logic [U-1:0]      digit;
  logic [XLEN+U-1:0] partial;
  logic [2*XLEN-1:0] acc_mul_n;
  logic [XLEN-1:0]   shift_mul_n;
  logic [XLEN:0]     rem_shift;
  logic              q_bit;
  logic [XLEN-1:0]   rem_new;
  logic [XLEN-1:0]   shift_div_n;

  assign is_mul_q = (kind_q == K_MUL_LO) || (kind_q == K_MUL_HI);

  always_comb begin
    // Multiply: (acc + partial << XLEN) >> U, computed without the discarded
    // low bits. The product of W-bit magnitudes lands at offset XLEN-W.
    digit       = shift_q[U-1:0];
    partial     = (XLEN+U)'(mcand_q) * (XLEN+U)'(digit);
    acc_mul_n   = {{U{1'b0}}, acc_q[2*XLEN-1:U]} + {partial, {(XLEN-U){1'b0}}};
    shift_mul_n = shift_q >> U;

    // Restoring divide: bring in the next dividend bit, subtract if it fits.
    rem_shift   = {acc_q[XLEN-1:0], shift_q[XLEN-1]};
    q_bit       = (rem_shift >= {1'b0, mcand_q});
    rem_new     = q_bit ? (rem_shift[XLEN-1:0] - mcand_q) : rem_shift[XLEN-1:0];
    shift_div_n = {shift_q[XLEN-2:0], q_bit};
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      cnt_q   <= '0;
      kind_q  <= K_MUL_LO;
      neg_q   <= 1'b0;
      w32_q   <= 1'b0;
      mcand_q <= '0;
      shift_q <= '0;
      acc_q   <= '0;
    end else if (accept) begin
      kind_q <= kind_in;
      w32_q  <= w32_in;
      acc_q  <= '0;
      if (is_mul_in) begin
        cnt_q   <= cnt_init;
        neg_q   <= neg_in;
        mcand_q <= a_mag;
        shift_q <= b_mag;
      end else if (div0) begin
        // Quotient all ones, remainder = raw dividend; no sign fix-up.
        cnt_q   <= '0;
        neg_q   <= 1'b0;
        mcand_q <= '0;
        shift_q <= '1;
        acc_q   <= {{XLEN{1'b0}}, a_w};
      end else if (ovf) begin
        // Quotient = -2^(W-1) is the dividend itself, remainder 0.
        cnt_q   <= '0;
        neg_q   <= 1'b0;
        mcand_q <= '0;
        shift_q <= a_w;
      end else begin
        cnt_q   <= cnt_init;
        neg_q   <= neg_in;
        mcand_q <= b_mag;
        // Left-align the dividend so its MSB is always shift_q[XLEN-1].
        shift_q <= w32_in ? (a_mag << (XLEN - 32)) : a_mag;
      end
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - CW'(1);
      if (is_mul_q) begin
        acc_q   <= acc_mul_n;
        shift_q <= shift_mul_n;
      end else begin
        acc_q   <= {{XLEN{1'b0}}, rem_new};
        shift_q <= shift_div_n;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Result formation (DONE only)
  // -------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, res_full, res_sel;
  logic [31:0]       res_word;

  always_comb begin
    prod   = w32_q ? (acc_q >> (XLEN - 32)) : acc_q;
    prod_s = neg_q ? -prod : prod;
    quot_s = neg_q ? -shift_q : shift_q;
    rem_s  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

    case (kind_q)
      K_MUL_LO: begin
        res_full = prod_s[XLEN-1:0];
        res_word = prod_s[31:0];
      end
      K_MUL_HI: begin
        res_full = prod_s[2*XLEN-1:XLEN];
        res_word = prod_s[63:32];
      end
      K_QUOT: begin
        res_full = quot_s;
        res_word = quot_s[31:0];
      end
      default: begin
        res_full = rem_s;
        res_word = rem_s[31:0];
      end
    endcase

    res_sel = w32_q ? sext_word(res_word) : res_full;
  end

  assign mdu.ready  = (state_q == DONE);
  assign mdu.busy   = (state_q != IDLE);
  assign mdu.result = (state_q == DONE) ? res_sel : '0;

endmodule

// File: tb/tb_core_pipe_exec_mdu.sv
// ---------------------------------------------------------------------------
// tb_core_pipe_exec_mdu
// Directed bench for core_pipe_exec_mdu. dut0 is XLEN=64/MUL_UNROLL=1,
// dut4 is XLEN=64/MUL_UNROLL=4. Cycle numbers count rising edges from the
// cycle in which the request is first presented (cycle 0).
// ---------------------------------------------------------------------------
module tb_core_pipe_exec_mdu;

  logic g_clk = 1'b0;
  logic g_reset;
  always #5 g_clk = ~g_clk;

  core_pipe_exec_mdu_if #(.XLEN(64)) bus0 ();
  core_pipe_exec_mdu_if #(.XLEN(64)) bus4 ();

  core_pipe_exec_mdu #(.XLEN(64), .MUL_UNROLL(1)) dut0 (
    .g_clk(g_clk), .g_reset(g_reset), .mdu(bus0.slave));
  core_pipe_exec_mdu #(.XLEN(64), .MUL_UNROLL(4)) dut4 (
    .g_clk(g_clk), .g_reset(g_reset), .mdu(bus4.slave));

  localparam logic [7:0] MUL = 8'h80, MULH = 8'h40, MULHSU = 8'h20, MULHU = 8'h10;
  localparam logic [7:0] DIV = 8'h08, DIVU = 8'h04, REM = 8'h02, REMU = 8'h01;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic v, input logic [7:0] ops,
                       input logic w, input logic [63:0] a, input logic [63:0] b);
    if (which == 0) begin
      bus0.valid = v;
      {bus0.op_mul, bus0.op_mulh, bus0.op_mulhsu, bus0.op_mulhu,
       bus0.op_div, bus0.op_divu, bus0.op_rem, bus0.op_remu} = ops;
      bus0.op_w = w; bus0.opr_a = a; bus0.opr_b = b;
    end else begin
      bus4.valid = v;
      {bus4.op_mul, bus4.op_mulh, bus4.op_mulhsu, bus4.op_mulhu,
       bus4.op_div, bus4.op_divu, bus4.op_rem, bus4.op_remu} = ops;
      bus4.op_w = w; bus4.opr_a = a; bus4.opr_b = b;
    end
  endtask

  function automatic logic rdy(input int which);
    return (which == 0) ? bus0.ready : bus4.ready;
  endfunction
  function automatic logic bsy(input int which);
    return (which == 0) ? bus0.busy : bus4.busy;
  endfunction
  function automatic logic [63:0] res(input int which);
    return (which == 0) ? bus0.result : bus4.result;
  endfunction

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  // Bounded wait for ready; an expired bound returns the limit.
  task automatic wait_ready(input int which, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!rdy(which) && cyc < 200);
  endtask

  task automatic count_ready(input int which, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (rdy(which)) cnt++;
    end
  endtask

  task automatic run(input int which, input logic [7:0] ops, input logic w,
                     input logic [63:0] a, input logic [63:0] b,
                     input int exp_cyc, input logic [63:0] exp_res, input string tag);
    int cyc;
    drive(which, 1'b1, ops, w, a, b);
    wait_ready(which, cyc);
    chk({tag, "/cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "/result"}, res(which), exp_res);
    drive(which, 1'b0, 8'h00, 1'b0, 64'd0, 64'd0);
    tick();
  endtask

  initial begin
    int cyc;
    int cnt;

    g_reset    = 1'b1;
    bus0.flush = 1'b0;
    bus4.flush = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0, 64'd0, 64'd0);
    drive(1, 1'b0, 8'h00, 1'b0, 64'd0, 64'd0);

    // Reset state, before any clock edge
    #2;
    chk("rst/ready", 64'(bus0.ready), 64'd0);
    chk("rst/busy", 64'(bus0.busy), 64'd0);
    chk("rst/result", bus0.result, 64'd0);
    chk("rst/busy4", 64'(bus4.busy), 64'd0);
    tick();
    g_reset = 1'b0;

    // Multiply, full width and word
    run(0, MUL, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 65, 64'hFFFF_FFFF_FFFF_FFF1, "mul3x-5");
    run(0, MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFE, "mulw");
    run(0, MULHSU, 1'b0, ONES, 64'h8000_0000_0000_0000, 65, ONES, "mulhsu");
    run(0, MULH, 1'b0, ONES, 64'h8000_0000_0000_0000, 65, 64'd0, "mulh_neg");

    // Divide by zero and signed overflow
    run(0, DIV, 1'b0, 64'd7, 64'd0, 1, ONES, "div0");
    run(0, REM, 1'b0, 64'd7, 64'd0, 1, 64'd7, "rem0");
    run(0, DIV, 1'b0, 64'h8000_0000_0000_0000, ONES, 1, 64'h8000_0000_0000_0000, "divovf");
    run(0, REM, 1'b0, 64'h8000_0000_0000_0000, ONES, 1, 64'd0, "removf");

    // Signed divide, full width and word (upper bits of word operand ignored)
    run(0, DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 65, 64'hFFFF_FFFF_FFFF_FFF2, "div-100/7");
    run(0, REM, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 65, 64'hFFFF_FFFF_FFFF_FFFE, "rem-100/7");
    run(0, DIV, 1'b1, 64'h1234_5678_FFFF_FF9C, 64'd7, 33, 64'hFFFF_FFFF_FFFF_FFF2, "divw");
    run(0, DIVU, 1'b1, 64'h0000_0000_8000_0005, 64'h1_0000_0000, 1, ONES, "divuw0");
    run(0, REMU, 1'b1, 64'h0000_0000_8000_0005, 64'h1_0000_0000, 1,
        64'hFFFF_FFFF_8000_0005, "remuw0");

    // Illegal op-select vectors are not accepted
    drive(0, 1'b1, 8'h00, 1'b0, 64'd5, 64'd3);
    repeat (3) tick();
    chk("noop/busy", 64'(bus0.busy), 64'd0);
    drive(0, 1'b1, MUL | DIV, 1'b0, 64'd5, 64'd3);
    repeat (3) tick();
    chk("multiop/busy", 64'(bus0.busy), 64'd0);
    drive(0, 1'b0, 8'h00, 1'b0, 64'd0, 64'd0);
    tick();

    // Operand/op changes while busy are ignored
    drive(0, 1'b1, DIVU, 1'b0, 64'd1000, 64'd10);
    tick();
    drive(0, 1'b1, REMU, 1'b0, 64'd5, 64'd3);
    wait_ready(0, cyc);
    chk("hold/cycle", 64'(cyc), 64'd64);
    chk("hold/result", bus0.result, 64'd100);
    drive(0, 1'b0, 8'h00, 1'b0, 64'd0, 64'd0);
    tick();

    // Flush at cycle 10
    drive(0, 1'b1, DIVU, 1'b0, 64'd100, 64'd7);
    repeat (10) tick();
    chk("flush/busy_before", 64'(bus0.busy), 64'd1);
    bus0.flush = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0, 64'd0, 64'd0);
    tick();
    chk("flush/busy_after", 64'(bus0.busy), 64'd0);
    chk("flush/ready_after", 64'(bus0.ready), 64'd0);
    bus0.flush = 1'b0;
    count_ready(0, 70, cnt);
    chk("flush/no_ready", 64'(cnt), 64'd0);
    run(0, REMU, 1'b0, 64'd100, 64'd7, 65, 64'd2, "remu_after_flush");

    // MUL_UNROLL=4 instance
    run(1, MUL, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 17, 64'hFFFF_FFFF_FFFF_FFF1, "u4/mul");
    run(1, MULHU, 1'b0, ONES, 64'h8000_0000_0000_0000, 17, 64'h7FFF_FFFF_FFFF_FFFF, "u4/mulhu");
    run(1, MULH, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 17, 64'd1, "u4/mulh");

    // Back-to-back: second request held on valid through DONE
    drive(1, 1'b1, MULHU, 1'b0, ONES, ONES);
    wait_ready(1, cyc);
    chk("b2b/cycle1", 64'(cyc), 64'd17);
    chk("b2b/result1", bus4.result, 64'hFFFF_FFFF_FFFF_FFFE);
    drive(1, 1'b1, MUL, 1'b0, 64'd6, 64'd7);
    tick();
    chk("b2b/idle_busy", 64'(bus4.busy), 64'd0);
    chk("b2b/idle_ready", 64'(bus4.ready), 64'd0);
    tick();
    chk("b2b/accepted", 64'(bus4.busy), 64'd1);
    wait_ready(1, cyc);
    chk("b2b/cycle2", 64'(cyc), 64'd16);
    chk("b2b/result2", bus4.result, 64'd42);
    drive(1, 1'b0, 8'h00, 1'b0, 64'd0, 64'd0);
    tick();

    // Asynchronous reset mid-operation
    drive(1, 1'b1, MUL, 1'b0, 64'd6, 64'd7);
    repeat (5) tick();
    chk("arst/busy_before", 64'(bus4.busy), 64'd1);
    g_reset = 1'b1;
    #1;
    chk("arst/busy", 64'(bus4.busy), 64'd0);
    chk("arst/ready", 64'(bus4.ready), 64'd0);
    chk("arst/result", bus4.result, 64'd0);
    drive(1, 1'b0, 8'h00, 1'b0, 64'd0, 64'd0);
    @(negedge g_clk);
    g_reset = 1'b0;
    count_ready(1, 30, cnt);
    chk("arst/no_ready", 64'(cnt), 64'd0);
    chk("arst/idle", 64'(bsy(1)), 64'd0);
    chk("arst/result_idle", res(1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
